red_pitaya_sort_scheduler: RTL and testbench

//  Queues sort requests from the FADS droplet evaluator and fires the sort trigger to the ASG/HV amplifier.

---
 rtl/red_pitaya_fads_pkg.sv | 17 +
 rtl/red_pitaya_sync_fifo.sv | 55 +++++
 rtl/red_pitaya_sort_scheduler.sv | 130 +++++++++++++
 tb/tb_red_pitaya_sort_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_fads_pkg.sv
// Shared FADS definitions: sort-scheduler FSM encodings and default sizing/timing.
// Imported by the sort scheduler and its FIFO.
package red_pitaya_fads_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_PULSE = 2'd1
  } sch_state_e;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_TSW   = 32;
  localparam int DEF_CW    = 32;

  localparam int unsigned DEF_SORT_DELAY    = 32'd31250;
  localparam int unsigned DEF_SORT_DURATION = 32'd125000;

endpackage

// File: rtl/red_pitaya_sync_fifo.sv
// Show-ahead synchronous FIFO; head_o is valid whenever empty_o is low, zero read latency.
// A push while full is taken only when a pop happens in the same cycle; clear_i flushes.
module red_pitaya_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [W-1:0]               dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_en, rd_en;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // The slot being read is freed in the same cycle, so a full push is safe with a pop.
  assign wr_en = push_i & (~full_o | pop_i) & ~clear_i;
  assign rd_en = pop_i & ~empty_o & ~clear_i;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= dat_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !rd_en)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!wr_en && rd_en) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/red_pitaya_sort_scheduler.sv
// Queues droplet sort requests and fires fixed-length ASG trigger pulses sort_delay cycles later.
// Trigger rises max(D,1) cycles after the request; a full queue drops requests; overlapping pulses merge.
module red_pitaya_sort_scheduler
  import red_pitaya_fads_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TSW   = DEF_TSW,
  parameter int CW    = DEF_CW
) (
  input  logic                     adc_clk_i,
  input  logic                     adc_rstn_i,
  input  logic                     req_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [TSW-1:0]           sort_delay_i,
  input  logic [31:0]              sort_duration_i,
  output logic                     sort_trig_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [CW-1:0]            fired_o,
  output logic [CW-1:0]            merged_o,
  output logic [CW-1:0]            dropped_o,
  output logic [1:0]               state_o
);
  sch_state_e      state_q, state_d;
  logic [TSW-1:0]  ts_q, head, age;
  logic [31:0]     pcnt_q, pcnt_d;
  logic            trig_q;
  logic [CW-1:0]   fired_q, merged_q, dropped_q;
  logic            push, pop, fire, merge, drop, full, empty, head_due;

  assign push = req_i & enable_i & ~clear_i;
  assign drop = push & full & ~pop;
  // Wrap-aware: head is due once ts has reached or passed it by less than half the range.
  assign age      = ts_q - head;
  assign head_due = ~empty & ~age[TSW-1];

  red_pitaya_sync_fifo #(.DEPTH(DEPTH), .W(TSW)) u_fifo (
    .clk_i   (adc_clk_i),
    .rstn_i  (adc_rstn_i),
    .clear_i (clear_i),
    .push_i  (push),
    .dat_i   (ts_q + sort_delay_i),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fill_o)
  );

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    pop     = 1'b0;
    fire    = 1'b0;
    merge   = 1'b0;
    unique case (state_q)
      SCH_IDLE: begin
        if (head_due) begin
          pop    = 1'b1;
          fire   = 1'b1;
          pcnt_d = sort_duration_i;
          if (sort_duration_i != 32'd0) state_d = SCH_PULSE;
        end
      end
      SCH_PULSE: begin
        if (head_due) begin
          pop   = 1'b1;
          fire  = 1'b1;
          merge = 1'b1;
        end
        // A zero-length merge adds nothing, so the running pulse simply continues.
        if (head_due && sort_duration_i != 32'd0) begin
          pcnt_d = sort_duration_i;
        end else if (pcnt_q == 32'd1) begin
          pcnt_d  = 32'd0;
          state_d = SCH_IDLE;
        end else begin
          pcnt_d = pcnt_q - 32'd1;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
    if (clear_i) begin
      state_d = SCH_IDLE;
      pcnt_d  = 32'd0;
      pop     = 1'b0;
      fire    = 1'b0;
      merge   = 1'b0;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q <= SCH_IDLE;
      pcnt_q  <= 32'd0;
      trig_q  <= 1'b0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= (state_d == SCH_PULSE);
      ts_q    <= ts_q + TSW'(1);
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      fired_q   <= '0;
      merged_q  <= '0;
      dropped_q <= '0;
    end else if (clear_i) begin
      fired_q   <= '0;
      merged_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (fire)  fired_q   <= fired_q + CW'(1);
      if (merge) merged_q  <= merged_q + CW'(1);
      if (drop)  dropped_q <= dropped_q + CW'(1);
    end
  end

  assign sort_trig_o = trig_q;
  assign busy_o      = ~empty | trig_q;
  assign fired_o     = fired_q;
  assign merged_o    = merged_q;
  assign dropped_o   = dropped_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_red_pitaya_sort_scheduler.sv
// Directed bench for the sort scheduler: expected pulses are queued as requests are issued
// and a negedge monitor matches every observed trigger pulse (start edge, length) against them.
module tb_red_pitaya_sort_scheduler;
  import red_pitaya_fads_pkg::*;

  localparam int DEPTH = 16;
  localparam int TSW   = 12;
  localparam int CW    = 32;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_i = 1'b0;
  logic           enable_i = 1'b1;
  logic           clear_i = 1'b0;
  logic [TSW-1:0] sort_delay_i = '0;
  logic [31:0]    sort_duration_i = '0;
  logic           sort_trig_o, busy_o;
  logic [FW-1:0]  fill_o;
  logic [CW-1:0]  fired_o, merged_o, dropped_o;
  logic [1:0]     state_o;

  red_pitaya_sort_scheduler #(.DEPTH(DEPTH), .TSW(TSW), .CW(CW)) dut (
    .adc_clk_i       (clk),
    .adc_rstn_i      (rst_n),
    .req_i           (req_i),
    .enable_i        (enable_i),
    .clear_i         (clear_i),
    .sort_delay_i    (sort_delay_i),
    .sort_duration_i (sort_duration_i),
    .sort_trig_o     (sort_trig_o),
    .busy_o          (busy_o),
    .fill_o          (fill_o),
    .fired_o         (fired_o),
    .merged_o        (merged_o),
    .dropped_o       (dropped_o),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  // Edge index: value k means the k-th rising edge since reset release has occurred.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct { int start; int len; } pulse_t;
  pulse_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: time each trigger pulse and compare it with the oldest expectation.
  logic   trig_prev = 1'b0;
  int     rise_cyc = 0;
  pulse_t got;
  always @(negedge clk) begin
    if (!rst_n) begin
      trig_prev = 1'b0;
    end else begin
      if (sort_trig_o && !trig_prev) rise_cyc = cyc;
      if (!sort_trig_o && trig_prev) begin
        check("pulse_was_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          check("pulse_start", 64'(rise_cyc), 64'(got.start));
          check("pulse_len", 64'(cyc - rise_cyc), 64'(got.len));
        end
      end
      trig_prev = sort_trig_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the request is sampled on the next rising edge, returned as k.
  task automatic do_req(output int k);
    k = cyc + 1;
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  task automatic expect_pulse(input int start, input int len);
    pulse_t p;
    p.start = start;
    p.len   = len;
    exp_q.push_back(p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2;
    #12;
    check("rst_trig", 64'(sort_trig_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_fill", 64'(fill_o), 64'd0);
    check("rst_fired", 64'(fired_o), 64'd0);
    check("rst_merged", 64'(merged_o), 64'd0);
    check("rst_dropped", 64'(dropped_o), 64'd0);
    check("rst_state", 64'(state_o), 64'(SCH_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Single request: D=10, dur=5.
    sort_delay_i = 12'd10;
    sort_duration_i = 32'd5;
    do_req(k);
    expect_pulse(k + 10, 5);
    check("t1_fill_after_push", 64'(fill_o), 64'd1);
    check("t1_busy", 64'(busy_o), 64'd1);
    tick(20);
    check("t1_fired", 64'(fired_o), 64'd1);
    check("t1_merged", 64'(merged_o), 64'd0);
    check("t1_fill", 64'(fill_o), 64'd0);
    check("t1_idle_busy", 64'(busy_o), 64'd0);
    check("t1_pending", 64'(exp_q.size()), 64'd0);

    // Two overlapping requests merge into one gap-free pulse.
    do_clear();
    do_req(k);
    tick(2);
    do_req(k2);
    check("t2_req_spacing", 64'(k2 - k), 64'd3);
    expect_pulse(k + 10, 8);
    tick(20);
    check("t2_fired", 64'(fired_o), 64'd2);
    check("t2_merged", 64'(merged_o), 64'd1);
    check("t2_pending", 64'(exp_q.size()), 64'd0);

    // Disabled request is ignored entirely.
    do_clear();
    enable_i = 1'b0;
    do_req(k);
    check("t6_dis_fill", 64'(fill_o), 64'd0);
    tick(15);
    enable_i = 1'b1;
    check("t6_dis_fired", 64'(fired_o), 64'd0);
    check("t6_dis_dropped", 64'(dropped_o), 64'd0);

    // Zero duration: counted as fired, no trigger pulse.
    sort_delay_i = 12'd2;
    sort_duration_i = 32'd0;
    do_req(k);
    tick(8);
    check("t6_dur0_fired", 64'(fired_o), 64'd1);
    check("t6_dur0_fill", 64'(fill_o), 64'd0);
    check("t6_dur0_state", 64'(state_o), 64'(SCH_IDLE));

    // Zero delay fires on the very next edge.
    sort_delay_i = 12'd0;
    sort_duration_i = 32'd4;
    do_req(k);
    expect_pulse(k + 1, 4);
    tick(10);
    check("t6_d0_fired", 64'(fired_o), 64'd2);
    check("t6_d0_pending", 64'(exp_q.size()), 64'd0);

    // 20 back-to-back requests into a 16-deep queue.
    do_clear();
    sort_delay_i = 12'd1000;
    sort_duration_i = 32'd3;
    k = cyc + 1;
    req_i = 1'b1;
    tick(20);
    req_i = 1'b0;
    check("t3_fill_full", 64'(fill_o), 64'd16);
    check("t3_dropped", 64'(dropped_o), 64'd4);
    check("t3_fired_early", 64'(fired_o), 64'd0);
    expect_pulse(k + 1000, 18);
    tick(1010);
    check("t3_fired", 64'(fired_o), 64'd16);
    check("t3_merged", 64'(merged_o), 64'd15);
    check("t3_fill", 64'(fill_o), 64'd0);
    check("t3_dropped_kept", 64'(dropped_o), 64'd4);
    check("t3_pending", 64'(exp_q.size()), 64'd0);

    // Clear mid-pulse with three entries still queued.
    do_clear();
    sort_delay_i = 12'd20;
    sort_duration_i = 32'd50;
    do_req(k);
    tick(9);
    do_req(k2);
    do_req(k2);
    do_req(k2);
    while (cyc < k + 24) @(negedge clk);
    check("t5_fill_before", 64'(fill_o), 64'd3);
    check("t5_trig_before", 64'(sort_trig_o), 64'd1);
    expect_pulse(k + 20, 5);
    do_clear();
    check("t5_trig", 64'(sort_trig_o), 64'd0);
    check("t5_fill", 64'(fill_o), 64'd0);
    check("t5_fired", 64'(fired_o), 64'd0);
    check("t5_merged", 64'(merged_o), 64'd0);
    check("t5_busy", 64'(busy_o), 64'd0);
    tick(40);
    do_req(k);
    expect_pulse(k + 20, 50);
    tick(80);
    check("t5_after_fired", 64'(fired_o), 64'd1);
    check("t5_pending", 64'(exp_q.size()), 64'd0);

    // Timestamp wrap: request at ts = 2^TSW-5 with D=10.
    do_clear();
    sort_delay_i = 12'd10;
    sort_duration_i = 32'd5;
    while (cyc < 4091) @(negedge clk);
    do_req(k);
    check("t4_req_edge", 64'(k), 64'd4092);
    expect_pulse(k + 10, 5);
    tick(25);
    check("t4_fired", 64'(fired_o), 64'd1);
    check("t4_pending", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset during a pulse kills it at once.
    sort_delay_i = 12'd0;
    sort_duration_i = 32'd100;
    do_req(k);
    do_req(k2);
    tick(4);
    check("ar_trig_before", 64'(sort_trig_o), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_trig", 64'(sort_trig_o), 64'd0);
    check("ar_fill", 64'(fill_o), 64'd0);
    check("ar_busy", 64'(busy_o), 64'd0);
    check("ar_fired", 64'(fired_o), 64'd0);
    check("ar_state", 64'(state_o), 64'(SCH_IDLE));
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
